// File: rtl/dice_pkg.sv
// Shared types and segment tables for the dice roll sequencer.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package dice_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SPIN = 2'd1,
    SLOW = 2'd2,
    SHOW = 2'd3
  } dice_state_t;

  localparam logic [2:0] FACE_MIN = 3'd1;
  localparam logic [2:0] FACE_MAX = 3'd6;
  localparam logic [2:0] FRAME_LAST = 3'd5;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // One outer segment lit, walking a -> f around the display.
  localparam logic [6:0] SPIN_FRAME [0:5] = '{
    7'b1111110, 7'b1111101, 7'b1111011,
    7'b1110111, 7'b1101111, 7'b1011111
  };

  localparam logic [6:0] DIGIT_SEG [1:6] = '{
    7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010
  };

  function automatic logic [2:0] frame_next(input logic [2:0] f);
    return (f >= FRAME_LAST) ? 3'd0 : f + 3'd1;
  endfunction

endpackage

// File: rtl/dice_rng.sv
// Free-running face counter 1..6; advances on every clock that is not in reset.
module dice_rng
  import dice_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [2:0] rng_o
);

  logic [2:0] rng_q;
  logic [2:0] rng_d;

  always_comb begin
    rng_d = (rng_q >= FACE_MAX) ? FACE_MIN : rng_q + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rng_q <= FACE_MIN;
    end else begin
      rng_q <= rng_d;
    end
  end

  assign rng_o = rng_q;

endmodule

// File: rtl/dice_roll_ctrl.sv
// Roll sequencer: fast constant-rate spin, decelerating spin, then show a latched face.
// All outputs are decoded from registered state only.
module dice_roll_ctrl
  import dice_pkg::*;
#(
  parameter int TICK_DIV   = 2_500_000,
  parameter int SPIN_STEPS = 24,
  parameter int SLOW_STEPS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       roll_btn,
  output logic [6:0] DISP,
  output logic [2:0] value,
  output logic       busy,
  output logic       done
);

  localparam int DIV_W  = $clog2(TICK_DIV << SLOW_STEPS);
  localparam int STEP_W = $clog2(SPIN_STEPS + 1);
  localparam int K_W    = $clog2(SLOW_STEPS + 1);

  dice_state_t       state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [2:0]        frame_q, frame_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [2:0]        result_q, result_d;
  logic              done_q, done_d;
  logic              btn_q;

  logic [2:0]            rng_val;
  logic                  rise;
  logic                  spin_tick;
  logic [SLOW_STEPS-1:0] slow_hit;
  logic                  slow_tick;

  dice_rng u_rng (
    .clk   (clk),
    .reset (reset),
    .rng_o (rng_val)
  );

  // btn_q resets high so a button held through reset cannot start a roll.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_q <= 1'b1;
    end else begin
      btn_q <= roll_btn;
    end
  end

  assign rise      = roll_btn & ~btn_q;
  assign spin_tick = (div_q == DIV_W'(TICK_DIV - 1));

  // One comparator per slow frame; only the one matching k_q can fire.
  for (genvar gi = 0; gi < SLOW_STEPS; gi++) begin : gen_slow_hit
    localparam int LAST = (TICK_DIV << (gi + 1)) - 1;
    assign slow_hit[gi] = (k_q == K_W'(gi + 1)) && (div_q == DIV_W'(LAST));
  end

  assign slow_tick = |slow_hit;

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    frame_d  = frame_q;
    step_d   = step_q;
    k_d      = k_q;
    result_d = result_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE, SHOW: begin
        if (rise) begin
          state_d  = SPIN;
          div_d    = '0;
          frame_d  = 3'd0;
          step_d   = '0;
          result_d = rng_val;
        end
      end
      SPIN: begin
        if (spin_tick) begin
          div_d   = '0;
          frame_d = frame_next(frame_q);
          step_d  = step_q + STEP_W'(1);
          if (step_q == STEP_W'(SPIN_STEPS - 1)) begin
            state_d = SLOW;
            k_d     = K_W'(1);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      SLOW: begin
        if (slow_tick) begin
          div_d   = '0;
          frame_d = frame_next(frame_q);
          if (k_q == K_W'(SLOW_STEPS)) begin
            state_d = SHOW;
            done_d  = 1'b1;
          end else begin
            k_d = k_q + K_W'(1);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      div_q    <= '0;
      frame_q  <= 3'd0;
      step_q   <= '0;
      k_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      frame_q  <= frame_d;
      step_q   <= step_d;
      k_q      <= k_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    DISP  = SEG_BLANK;
    value = 3'd0;
    case (state_q)
      SPIN, SLOW: begin
        if (frame_q <= FRAME_LAST) DISP = SPIN_FRAME[frame_q];
      end
      SHOW: begin
        value = result_q;
        if (result_q >= FACE_MIN && result_q <= FACE_MAX) DISP = DIGIT_SEG[result_q];
      end
      default: ;
    endcase
  end

  assign busy = (state_q == SPIN) || (state_q == SLOW);
  assign done = done_q;

endmodule
